// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mips_pkg
//  Purpose   : Shared definitions for the MIPS EX-stage operand logic:
//              ALU control codes, R-type funct values, ALUOp encodings,
//              forwarding-select enum, ID/EX control bundle and the
//              ALUOp/funct -> ALU control decoder.
//  Revision  : 1.0  initial release
// ============================================================================
package mips_pkg;

  // ALU control codes seen by the ALU
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  // R-type function field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // Operand source chosen by the forwarding unit
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // Control portion of the ID/EX register
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [5:0] funct;
  } idex_ctrl_t;

  // ALUOp/funct -> ALU control. Unsupported R-type funct yields ALU_INVALID.
  function automatic logic [3:0] alu_decode(input logic [1:0] op,
                                            input logic [5:0] funct);
    logic [3:0] code;
    code = ALU_ADD;
    case (op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_ORI: code = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_SLT: code = ALU_SLT;
          FUNCT_NOR: code = ALU_NOR;
          default:   code = ALU_INVALID;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
//  Module    : forward_unit
//  Purpose   : Selects the source of one EX operand. EX/MEM has priority
//              over MEM/WB; register index 0 never forwards.
//  Ports     : idx_i              - registered source register index
//              exmem_reg_write_i  - EX/MEM will write a register
//              exmem_rd_i         - EX/MEM destination index
//              memwb_reg_write_i  - MEM/WB will write a register
//              memwb_rd_i         - MEM/WB destination index
//              sel_o              - chosen operand source
//  Revision  : 1.0  initial release
// ============================================================================
module forward_unit
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_rd_i,
  output fwd_sel_e      sel_o
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
  assign w_memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);

  always_comb begin
    sel_o = FWD_REG;
    if (w_exmem_hit)      sel_o = FWD_EXMEM;
    else if (w_memwb_hit) sel_o = FWD_MEMWB;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module    : id_ex_operand_stage
//  Purpose   : ID/EX pipeline register plus EX operand preparation:
//              forwarding muxes, ALU control decode and load-use detection.
//  Ports     : clk, reset (async, active-high), stall, flush
//              id_*       - decoded instruction fields from ID
//              exmem_*    - EX/MEM forwarding source
//              memwb_*    - MEM/WB forwarding source
//              alu_a/alu_b/alu_control - ALU inputs
//              store_data - forwarded rt for MEM
//              ex_dest, ex_valid, ex_reg_write, ex_mem_read,
//              ex_mem_write, ex_mem_to_reg - EX-stage outputs
//              illegal_op - unsupported funct on a valid R-type
//              load_use_stall - stall request back to ID
//  Revision  : 1.0  initial release
// ============================================================================
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_control,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          illegal_op,
  output logic          load_use_stall
);

  // --------------------------------------------------------------------------
  // ID/EX register
  // --------------------------------------------------------------------------
  idex_ctrl_t    ctrl_q,    ctrl_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q,     imm_d;
  logic [RW-1:0] rs_q,      rs_d;
  logic [RW-1:0] rt_q,      rt_d;
  logic [RW-1:0] rd_q,      rd_d;

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (flush) begin
      // Bubble: everything cleared, so indices of 0 cannot forward or hazard.
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else if (!stall) begin
      ctrl_d.valid      = id_valid;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d.reg_dst    = id_reg_dst;
      ctrl_d.alu_op     = id_alu_op;
      ctrl_d.funct      = id_funct;
      rs_data_d         = id_rs_data;
      rt_data_d         = id_rt_data;
      imm_d             = id_imm;
      rs_d              = id_rs;
      rt_d              = id_rt;
      rd_d              = id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;   // alu_op 00 -> alu_control reads as ADD
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  fwd_sel_e      w_sel_rs;
  fwd_sel_e      w_sel_rt;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  forward_unit #(.RW(RW)) u_fwd_rs (
    .idx_i             (rs_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .sel_o             (w_sel_rs)
  );

  forward_unit #(.RW(RW)) u_fwd_rt (
    .idx_i             (rt_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .sel_o             (w_sel_rt)
  );

  always_comb begin
    w_fwd_rs = rs_data_q;
    case (w_sel_rs)
      FWD_EXMEM: w_fwd_rs = exmem_result;
      FWD_MEMWB: w_fwd_rs = memwb_result;
      default:   w_fwd_rs = rs_data_q;
    endcase
  end

  always_comb begin
    w_fwd_rt = rt_data_q;
    case (w_sel_rt)
      FWD_EXMEM: w_fwd_rt = exmem_result;
      FWD_MEMWB: w_fwd_rt = memwb_result;
      default:   w_fwd_rt = rt_data_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // EX outputs
  // --------------------------------------------------------------------------
  logic [3:0] w_alu_code;

  assign w_alu_code  = alu_decode(ctrl_q.alu_op, ctrl_q.funct);
  assign alu_control = w_alu_code;
  assign illegal_op  = ctrl_q.valid && (ctrl_q.alu_op == ALUOP_RTYPE)
                       && (w_alu_code == ALU_INVALID);

  assign alu_a      = w_fwd_rs;
  assign store_data = w_fwd_rt;
  assign alu_b      = ctrl_q.alu_src ? imm_q : w_fwd_rt;
  assign ex_dest    = ctrl_q.reg_dst ? rd_q : rt_q;

  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write & ctrl_q.valid;
  assign ex_mem_read   = ctrl_q.mem_read  & ctrl_q.valid;
  assign ex_mem_write  = ctrl_q.mem_write & ctrl_q.valid;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

  // A load in EX whose destination is read by the instruction in ID.
  assign load_use_stall = ctrl_q.valid && ctrl_q.mem_read && (rt_q != '0)
                          && ((rt_q == id_rs) || (rt_q == id_rt));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module    : tb_id_ex_operand_stage
//  Purpose   : Directed self-checking bench for id_ex_operand_stage.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] alu_a, alu_b, store_data;
  logic [3:0]    alu_control;
  logic [RW-1:0] ex_dest;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          illegal_op, load_use_stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .illegal_op(illegal_op), .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = 2'b00; id_funct = '0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic fwd_clear();
    exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall = 0; flush = 0;
    id_clear();
    fwd_clear();
    #12;
    // ---- reset state ----
    chk("rst_valid",   {31'd0, ex_valid}, 32'd0);
    chk("rst_aluctl",  {28'd0, alu_control}, 32'h2);
    chk("rst_alu_a",   alu_a, 32'd0);
    chk("rst_dest",    {27'd0, ex_dest}, 32'd0);
    chk("rst_lus",     {31'd0, load_use_stall}, 32'd0);
    reset = 0;

    // ---- load R-type add, then reset mid-cycle ----
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100000;
    id_rs_data = 32'hDEAD0001; id_rt_data = 32'h00000005;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_dst = 1; id_reg_write = 1;
    tick();
    chk("add_aluctl",  {28'd0, alu_control}, 32'h2);
    chk("add_valid",   {31'd0, ex_valid}, 32'd1);
    chk("add_dest",    {27'd0, ex_dest}, 32'd3);
    chk("add_rw",      {31'd0, ex_reg_write}, 32'd1);
    chk("add_alu_a",   alu_a, 32'hDEAD0001);
    #1 reset = 1;
    #1;
    chk("arst_valid",  {31'd0, ex_valid}, 32'd0);
    chk("arst_rw",     {31'd0, ex_reg_write}, 32'd0);
    chk("arst_alu_a",  alu_a, 32'd0);
    chk("arst_alu_b",  alu_b, 32'd0);
    chk("arst_aluctl", {28'd0, alu_control}, 32'h2);
    chk("arst_dest",   {27'd0, ex_dest}, 32'd0);
    #1 reset = 0;

    // ---- R-type decode ----
    id_clear();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100111;
    id_rs_data = 32'h0F0F0000; id_rt_data = 32'h00FF00FF; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    chk("nor_aluctl",  {28'd0, alu_control}, 32'hC);
    chk("nor_alu_a",   alu_a, 32'h0F0F0000);
    chk("nor_alu_b",   alu_b, 32'h00FF00FF);
    chk("nor_illegal", {31'd0, illegal_op}, 32'd0);
    id_funct = 6'b000000;
    tick();
    chk("bad_aluctl",  {28'd0, alu_control}, 32'hF);
    chk("bad_illegal", {31'd0, illegal_op}, 32'd1);
    id_funct = 6'b101010;
    tick();
    chk("slt_aluctl",  {28'd0, alu_control}, 32'h7);
    id_alu_op = 2'b01; id_funct = 6'b000000;
    tick();
    chk("sub_aluctl",  {28'd0, alu_control}, 32'h6);
    chk("sub_illegal", {31'd0, illegal_op}, 32'd0);
    // Invalid R-type with bad funct must not flag illegal.
    id_valid = 0; id_alu_op = 2'b10;
    tick();
    chk("inv_illegal", {31'd0, illegal_op}, 32'd0);

    // ---- double forward on rs ----
    id_clear();
    id_valid = 1; id_rs = 5'd5; id_rs_data = 32'hAA; id_rt = 5'd9; id_rt_data = 32'h99;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    chk("fwd_both",    alu_a, 32'h11);
    chk("fwd_rt_none", store_data, 32'h99);
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb",   alu_a, 32'h22);
    exmem_reg_write = 1; exmem_rd = 5'd0;
    #1;
    chk("fwd_ex0",     alu_a, 32'h22);
    memwb_rd = 5'd0;
    #1;
    chk("fwd_none",    alu_a, 32'hAA);
    fwd_clear();

    // ---- index 0 never forwards ----
    id_clear();
    id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h77;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h55;
    #1;
    chk("fwd_idx0",    alu_a, 32'h77);
    fwd_clear();

    // ---- immediate path with forwarded rt ----
    id_clear();
    id_valid = 1; id_alu_op = 2'b11; id_alu_src = 1; id_imm = 32'hFFFFFFFC;
    id_rt = 5'd6; id_rt_data = 32'h44;
    tick();
    memwb_reg_write = 1; memwb_rd = 5'd6; memwb_result = 32'h33;
    #1;
    chk("imm_alu_b",   alu_b, 32'hFFFFFFFC);
    chk("imm_store",   store_data, 32'h33);
    chk("ori_aluctl",  {28'd0, alu_control}, 32'h1);
    fwd_clear();

    // ---- load-use hazard, then flush+stall ----
    id_clear();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_alu_src = 1; id_rt = 5'd8; id_rs = 5'd4;
    tick();
    id_clear();
    id_rs = 5'd8; id_rt = 5'd9;
    #1;
    chk("lu_stall",    {31'd0, load_use_stall}, 32'd1);
    chk("lu_dest",     {27'd0, ex_dest}, 32'd8);
    chk("lu_mrd",      {31'd0, ex_mem_read}, 32'd1);
    id_rs = 5'd3; id_rt = 5'd8;
    #1;
    chk("lu_stall_rt", {31'd0, load_use_stall}, 32'd1);
    id_rt = 5'd3;
    #1;
    chk("lu_nomatch",  {31'd0, load_use_stall}, 32'd0);
    id_rs = 5'd8; id_valid = 1; id_reg_write = 1; id_mem_write = 1;
    flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0;
    chk("fl_valid",    {31'd0, ex_valid}, 32'd0);
    chk("fl_rw",       {31'd0, ex_reg_write}, 32'd0);
    chk("fl_mrd",      {31'd0, ex_mem_read}, 32'd0);
    chk("fl_mwr",      {31'd0, ex_mem_write}, 32'd0);
    chk("fl_m2r",      {31'd0, ex_mem_to_reg}, 32'd0);
    chk("fl_lus",      {31'd0, load_use_stall}, 32'd0);

    // ---- load with rt=0 never hazards ----
    id_clear();
    id_valid = 1; id_mem_read = 1; id_rt = 5'd0;
    tick();
    id_clear();
    #1;
    chk("lu_idx0",     {31'd0, load_use_stall}, 32'd0);

    // ---- stall hold ----
    id_clear();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010;
    id_rs_data = 32'h1234; id_rt_data = 32'h5678; id_rs = 5'd10; id_rt = 5'd11;
    id_rd = 5'd7; id_reg_dst = 1; id_reg_write = 1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = 32'hF000 + i; id_rt_data = 32'hE000 + i; id_rd = 5'd20 + 5'(i);
      id_funct = 6'b100100; id_reg_dst = 0; id_valid = 0;
      tick();
      chk("hold_alu_a",  alu_a, 32'h1234);
      chk("hold_alu_b",  alu_b, 32'h5678);
      chk("hold_aluctl", {28'd0, alu_control}, 32'h6);
      chk("hold_dest",   {27'd0, ex_dest}, 32'd7);
      chk("hold_valid",  {31'd0, ex_valid}, 32'd1);
    end
    stall = 0;
    tick();
    chk("rel_alu_a",   alu_a, 32'hF002);
    chk("rel_aluctl",  {28'd0, alu_control}, 32'h0);
    chk("rel_dest",    {27'd0, ex_dest}, 32'd11);
    chk("rel_valid",   {31'd0, ex_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and EX-stage operand preparation for the five-stage MIPS core; sits directly upstream of the ALU and drives its `A`, `B` and 4-bit `ALUControl` inputs. It latches decoded instruction fields from ID each cycle, resolves EX/MEM and MEM/WB forwarding, decodes `ALUOp`/`funct` into the ALU control code, and flags load-use hazards back to ID. Stall and flush inputs from the hazard logic freeze the register or insert a bubble.

## Interface
- `DW`, 32, datapath width
- `RW`, 5, register index width
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-high; clears all registered state
- `stall` in 1, hold ID/EX contents
- `flush` in 1, load a bubble (priority over `stall`)
- `id_valid` in 1, ID holds a real instruction
- `id_rs_data`, `id_rt_data`, `id_imm` in DW each, register-file reads and sign-extended immediate
- `id_rs`, `id_rt`, `id_rd` in RW each, register indices
- `id_alu_op` in 2, 00 add, 01 sub, 10 R-type, 11 or-immediate
- `id_funct` in 6, R-type function field
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1 each
- `exmem_reg_write` in 1, `exmem_rd` in RW, `exmem_result` in DW, EX/MEM forwarding source
- `memwb_reg_write` in 1, `memwb_rd` in RW, `memwb_result` in DW, MEM/WB forwarding source
- `alu_a`, `alu_b` out DW, ALU operands
- `alu_control` out 4, ALU operation code
- `store_data` out DW, forwarded rt value for MEM
- `ex_dest` out RW, write-back register index
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1 each
- `illegal_op` out 1, unsupported funct on a valid R-type
- `load_use_stall` out 1, request to stall IF/ID and flush ID/EX

## Operation
- Each `clk` edge: `flush`=1 → `valid` and all control bits (`reg_write`, `mem_read`, `mem_write`, `mem_to_reg`) cleared, data/index fields don't-care (implementation clears them); else `stall`=1 → hold; else capture all `id_*` inputs.
- Forwarding, per source operand (rs, rt) independently, combinational from registered indices:
  - EX/MEM match: `exmem_reg_write` && `exmem_rd`≠0 && `exmem_rd`==index → `exmem_result`.
  - Else MEM/WB match under the same rule → `memwb_result`.
  - Else registered register-file value. EX/MEM always wins when both match.
- `alu_a` = forwarded rs; `store_data` = forwarded rt; `alu_b` = `alu_src` ? registered imm : forwarded rt.
- `ex_dest` = `reg_dst` ? rd : rt.
- ALU control: op 00→0010; 01→0110; 11→0001; 10 decodes funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100, any other→1111 with `illegal_op`=`valid`.
- `illegal_op` is 0 whenever `valid`=0 or op≠10.
- `load_use_stall` = `valid` && `mem_read` && registered rt≠0 && (registered rt==`id_rs` || registered rt==`id_rt`).
- Control outputs `ex_reg_write`, `ex_mem_read`, `ex_mem_write` are the registered bits ANDed with `valid`.

## Timing
- Latency: ID inputs visible at EX outputs one cycle after capture edge.
- Forwarding, ALU decode, `load_use_stall`: purely combinational from registered state plus same-cycle EX/MEM, MEM/WB, `id_rs`/`id_rt`; no added cycles.
- Reset (asserted any time, including mid-stall): immediately `ex_valid`=0, all control outs 0, `alu_a`=`alu_b`=`store_data`=0, `alu_control`=0010, `ex_dest`=0, `illegal_op`=0, `load_use_stall`=0; forwarding cannot fire because reset indices are 0.
- `stall` and `flush` both high → flush.
- Index 0 is never forwarded nor hazarded.

## Structure
- Shared package `mips_pkg`: ALU control codes (AND/OR/ADD/SUB/SLT/NOR/INVALID), funct constants, `ALUOp` encodings, forwarding-select enum (REG, EXMEM, MEMWB).
- One sub-module `forward_unit`: takes an index and both forwarding sources, returns select; instantiated twice (rs, rt).

## Test plan
- Reset mid-operation: load R-type add, assert `reset` → outputs drop asynchronously to reset values listed above, `alu_control`=0010.
- R-type decode: op 10, funct 100111, rs_data=0x0F0F0000, rt_data=0x00FF00FF → next cycle `alu_control`=1100, `alu_a`=0x0F0F0000, `alu_b`=0x00FF00FF; funct 000000 → 1111, `illegal_op`=1.
- Double forward: ex rs=5, `exmem_rd`=5 result 0x11, `memwb_rd`=5 result 0x22, both write → `alu_a`=0x11; drop `exmem_reg_write` → 0x22; `exmem_rd`=0 → no forward.
- Immediate path: `alu_src`=1, imm=0xFFFFFFFC, rt forwarded 0x33 → `alu_b`=0xFFFFFFFC, `store_data`=0x33.
- Load-use: lw with rt=8 in EX, `id_rs`=8 → `load_use_stall`=1; then `flush`+`stall` together → next cycle `ex_valid`=0, all control outs 0.
- Stall hold: capture instruction, `stall`=1 three cycles with changing `id_*` → EX outputs unchanged.
